// File: rtl/smart_house_zoned.sv
// Home controller: curtain/light/music ambient control, round-robin per-zone
// cooler/heater control with a hysteresis band, and doorbell-driven music mute.
module smart_house_zoned #(
  parameter int unsigned ZONES     = 4,
  parameter int unsigned TEMP_W    = 8,
  parameter int unsigned HOT_TH    = 30,
  parameter int unsigned COLD_TH   = 16,
  parameter int unsigned TARGET    = 24,
  parameter int unsigned HYST      = 1,
  parameter int unsigned RING_HOLD = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      isday,
  input  logic                      ring_req,
  input  logic [ZONES*TEMP_W-1:0]   temp_req,
  input  logic [ZONES-1:0]          zone_en,
  output logic                      music,
  output logic                      curtain,
  output logic                      light,
  output logic [ZONES-1:0]          cooler,
  output logic [ZONES-1:0]          heater,
  output logic                      ring_busy,
  output logic                      scan_done
);

  localparam int unsigned IDX_W = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int unsigned CNT_W = $clog2(RING_HOLD + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ZONES - 1);
  localparam logic [TEMP_W-1:0] HOT_T    = TEMP_W'(HOT_TH);
  localparam logic [TEMP_W-1:0] COLD_T   = TEMP_W'(COLD_TH);
  localparam logic [TEMP_W-1:0] BAND_LO  = TEMP_W'(TARGET - HYST);
  localparam logic [TEMP_W-1:0] BAND_HI  = TEMP_W'(TARGET + HYST);
  localparam logic [CNT_W-1:0]  HOLD_C   = CNT_W'(RING_HOLD);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_AMBIENT,
    S_ZONE,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               day_mode_q;
  logic               day_mode_d;
  logic [CNT_W-1:0]   mute_q;
  logic [CNT_W-1:0]   mute_d;
  logic               music_q;
  logic               curtain_q;
  logic               light_q;
  logic               ring_busy_q;
  logic               scan_done_q;
  logic [ZONES-1:0]   cooler_q;
  logic [ZONES-1:0]   heater_q;
  logic [TEMP_W-1:0]  zone_t;
  logic               cool_sel_d;
  logic               heat_sel_d;

  // Climate decision for the zone currently addressed by the scan index.
  always_comb begin
    zone_t     = temp_req[idx_q*TEMP_W +: TEMP_W];
    cool_sel_d = cooler_q[idx_q];
    heat_sel_d = heater_q[idx_q];
    if (!zone_en[idx_q]) begin
      cool_sel_d = 1'b0;
      heat_sel_d = 1'b0;
    end else if (zone_t >= HOT_T) begin
      cool_sel_d = 1'b1;
      heat_sel_d = 1'b0;
    end else if (zone_t <= COLD_T) begin
      cool_sel_d = 1'b0;
      heat_sel_d = 1'b1;
    end else if ((zone_t >= BAND_LO) && (zone_t <= BAND_HI)) begin
      cool_sel_d = 1'b0;
      heat_sel_d = 1'b0;
    end
  end

  // Mute counter and day mode run independently of the scan position.
  always_comb begin
    mute_d     = '0;
    day_mode_d = day_mode_q;
    if (ring_req) begin
      mute_d = HOLD_C;
    end else if (mute_q != '0) begin
      mute_d = mute_q - CNT_W'(1);
    end
    if (state_q == S_AMBIENT) begin
      day_mode_d = isday;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      day_mode_q  <= 1'b0;
      mute_q      <= '0;
      music_q     <= 1'b0;
      curtain_q   <= 1'b0;
      light_q     <= 1'b0;
      ring_busy_q <= 1'b0;
      scan_done_q <= 1'b0;
      cooler_q    <= '0;
      heater_q    <= '0;
    end else begin
      mute_q      <= mute_d;
      ring_busy_q <= (mute_d != '0);
      day_mode_q  <= day_mode_d;
      music_q     <= day_mode_d & (mute_d == '0);
      scan_done_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          state_q <= S_AMBIENT;
        end
        S_AMBIENT: begin
          curtain_q <= isday;
          light_q   <= ~isday;
          idx_q     <= '0;
          state_q   <= S_ZONE;
        end
        S_ZONE: begin
          cooler_q[idx_q] <= cool_sel_d;
          heater_q[idx_q] <= heat_sel_d;
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          scan_done_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign music     = music_q;
  assign curtain   = curtain_q;
  assign light     = light_q;
  assign cooler    = cooler_q;
  assign heater    = heater_q;
  assign ring_busy = ring_busy_q;
  assign scan_done = scan_done_q;

endmodule

// File: doc/smart_house_zoned.md
Name: smart_house_zoned

Overview:
- Next-generation home controller: ambient control (curtain, light, music) plus per-zone climate control (cooler/heater) for ZONES rooms.
- A round-robin scan FSM evaluates one zone per cycle against parametrised thresholds, with a hysteresis band around the target temperature.
- Doorbell ring mutes music for a programmable hold time.
- Sits between the sensor/bus interface and the actuator drivers.

Parameters:
ZONES, 4, number of climate zones (>=1)
TEMP_W, 8, unsigned temperature width per zone
HOT_TH, 30, temp >= HOT_TH turns cooler on
COLD_TH, 16, temp <= COLD_TH turns heater on
TARGET, 24, centre of the switch-off band
HYST, 1, half-width of the switch-off band; legal only when COLD_TH < TARGET-HYST and TARGET+HYST < HOT_TH
RING_HOLD, 8, music mute length in cycles after ring_req (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
isday  input  1  1 = day mode, sampled in AMBIENT
ring_req  input  1  doorbell, sampled every cycle
temp_req  input  ZONES*TEMP_W  zone i temperature at bits [i*TEMP_W +: TEMP_W]
zone_en  input  ZONES  1 = zone climate enabled
music  output  1  music on
curtain  output  1  curtain open
light  output  1  light on
cooler  output  ZONES  per-zone cooler on
heater  output  ZONES  per-zone heater on
ring_busy  output  1  mute counter nonzero
scan_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset is synchronous: reset=1 at an edge sets all outputs to 0, mute_cnt=0, zone index=0, day_mode=0, state=INIT. Applies mid-scan and mid-mute alike.
- The block powers up in INIT.
- FSM states:
  - INIT: 1 cycle, then IDLE.
  - IDLE: 1 cycle, then AMBIENT.
  - AMBIENT: latch day_mode<=isday. If isday=1, curtain<=1 and light<=0. If isday=0, curtain<=0 and light<=1. Then ZONE with idx=0.
  - ZONE: evaluate zone idx. If idx==ZONES-1, go to DONE; otherwise idx<=idx+1 and stay in ZONE.
  - DONE: scan_done<=1 for this cycle only, then IDLE.
- Scan period = ZONES+3 cycles (IDLE, AMBIENT, ZONES x ZONE, DONE).
- Zone evaluation (t = zone slice, sampled only in that zone's ZONE cycle, unsigned compare). First match wins:
  1. zone_en[idx]=0: cooler[idx]<=0, heater[idx]<=0.
  2. t>=HOT_TH: cooler[idx]<=1, heater[idx]<=0.
  3. t<=COLD_TH: heater[idx]<=1, cooler[idx]<=0.
  4. TARGET-HYST <= t <= TARGET+HYST: both <=0.
  5. Otherwise both hold their previous values (hysteresis).
- Invariant: cooler[i]&heater[i] is never 1.
- Outputs of zones not being evaluated never change.
- Mute counter runs every cycle outside reset, independent of FSM state:
  - mute_next = ring_req ? RING_HOLD : (mute_cnt ? mute_cnt-1 : 0).
  - A ring during an active mute reloads the counter to RING_HOLD.
  - ring_busy = (mute_cnt != 0), registered.
- music is registered and updated every cycle: music <= day_mode_next & (mute_next == 0).
  - A single-cycle ring sampled at edge k gives music=0 from edge k through edge k+RING_HOLD-1; music returns to 1 at edge k+RING_HOLD if still in day mode.
- Counter width is clog2(RING_HOLD+1); the index register is sized for ZONES-1. There is no wrap beyond ZONES-1.

Test Plan:
- Reset, then isday=1, all temps 20, zone_en=4'hF -> AMBIENT at cycle 2 after INIT. curtain=1, light=0, music=1, cooler=heater=0. scan_done pulses every 7 cycles.
- Temps {z0=35, z1=10, z2=24, z3=30}, all enabled -> after one scan cooler=4'b1001, heater=4'b0010. Then set z0=27 -> cooler[0] stays 1 (hold band). Then set z0=25 -> cooler[0]=0 at z0's next ZONE cycle.
- isday=1, single-cycle ring_req at edge k, RING_HOLD=8 -> music=0 and ring_busy=1 for edges k..k+7, music=1 at k+8. A second ring at k+5 -> music stays 0 until k+13.
- zone_en[1] cleared while heater[1]=1 (z1=10) -> heater[1]=0 at zone 1's next evaluation cycle; other zones unchanged.
- isday=0 -> light=1, curtain=0, music=0. A ring then has no music effect, but ring_busy still asserts for 8 cycles.
- reset asserted during ZONE idx=2 with cooler=4'b0001 and mute active -> next edge all outputs 0, ring_busy=0. A full scan restarts from INIT after release.
